wfg_axis_merge: RTL
===================

Name: wfg_axis_merge

Overview:
- Fan-in counterpart to the stimulus-to-driver interconnect: merges two AXI-Stream sources into one sink.
- Arbitrates per beat and registers the winning beat in a single output stage.
- Tags each output beat with the index of its source.
- Sits between driver-side capture/loopback streams and a common consumer, e.g. a readback FIFO.

Parameters:
- AXIS_DATA_WIDTH, 32, stream data width; fixed at 32 to match axis_t.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: one clock; reset is synchronous and active-high
- ctrl_en_q_i  input  1  block enable
- src_en_q_i  input  2  per-source enable mask; bit k enables source k
- arb_mode_q_i  input  1  0 = round-robin, 1 = fixed priority, source 0 highest
- source_0  input  axis_t(33)  source 0 stream: tvalid, tdata[31:0]
- source_1  input  axis_t(33)  source 1 stream
- wfg_axis_tready_source_0  output  1  ready to source 0
- wfg_axis_tready_source_1  output  1  ready to source 1
- merged  output  axis_t(33)  merged stream, registered
- merged_tid_o  output  1  source index of the current merged beat
- wfg_axis_tready_merged  input  1  ready from sink

Behaviour:
- Reset values (rst high at a clk edge):
  - merged.tvalid=0, merged.tdata=0, merged_tid_o=0.
  - Both source treadys 0.
  - last_grant=1, so source 0 wins the first contention.
  - Any held beat is discarded, including when rst is asserted mid-transfer.
- Source transfer: occurs on a cycle where the source's tvalid and tready are both 1.
- Sink transfer: occurs on a cycle where merged.tvalid and wfg_axis_tready_merged are both 1.
- Load condition: load = !merged.tvalid || wfg_axis_tready_merged. This gives full throughput of 1 beat/cycle.
- Request: req[k] = source_k.tvalid && src_en_q_i[k] && ctrl_en_q_i.
- Grant (combinational, one-hot or none):
  - If only one request is active, that source is granted.
  - If both are active and arb_mode_q_i=1, source 0 is granted.
  - If both are active and arb_mode_q_i=0, the source != last_grant is granted.
- tready to source k = load && grant[k]. A source tready may depend on its own tvalid (AXIS permitted). At most one source tready is high per cycle.
- On a source transfer:
  - merged.tdata <= source data, merged_tid_o <= k, merged.tvalid <= 1 on the next edge. Input-to-output latency is 1 cycle.
  - last_grant <= k.
- Sink transfer with no new source transfer in the same cycle: merged.tvalid <= 0 on the next edge.
- Sink transfer and source transfer in the same cycle: the new beat replaces the old one and merged.tvalid stays 1. No bubble, no loss.
- Output hold: while merged.tvalid=1 and the sink is not ready, merged.tdata and merged_tid_o are held stable.
- Grant changes only on a transfer; last_grant is not updated on idle cycles.
- ctrl_en_q_i low:
  - No new beats are accepted; both source treadys are 0.
  - A beat already held stays valid until the sink accepts it; it is never dropped.
- src_en_q_i[k] low: source k is never granted; the other source runs at full rate.
- arb_mode_q_i change: takes effect on the next arbitration; last_grant is retained.

Optional Feature:
- Macro: WFG_AXIS_MERGE_CNT_EN.
- Defined:
  - Adds outputs beat_cnt_0_o[15:0] and beat_cnt_1_o[15:0].
  - Counter k increments by 1 on each source-k transfer and wraps 0xFFFF -> 0x0000.
  - Input cnt_clr_i (1) synchronously clears both counters. If clear and increment occur in the same cycle, clear wins and the count is 0.
  - Counters reset to 0 on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
1. Reset, then sink ready=1, en=1, mask=11, mode=0, both sources continuously valid with 0xA0000000+n and 0xB0000000+n. -> Output alternates tid 0,1,0,1 starting with tid 0; one beat per cycle; first output the cycle after the first handshake.
2. Mode=1, both sources valid, sink ready=1. -> Only source 0 is granted; tready_source_1 stays 0; tid always 0.
3. Single source 1 valid with 0x12345678, sink ready=0 for 5 cycles. -> merged holds 0x12345678, tid=1, valid=1 for all 5 cycles; tready_source_1=0 after capture. When sink ready rises, next beat is accepted with no bubble cycle.
4. Beat held with sink stalled, deassert ctrl_en_q_i, then raise sink ready. -> Held beat is delivered; no further source transfers; merged.tvalid=0 the following cycle.
5. Mask=10, both sources valid. -> Only source 1 beats appear; source 0 tready stays 0. Assert rst mid-stream -> merged.tvalid=0 next cycle; after release, source 0 wins first contention once re-enabled.
6. With WFG_AXIS_MERGE_CNT_EN: preload via 65535 source-0 transfers -> beat_cnt_0_o=0xFFFF; next transfer -> 0x0000. Assert cnt_clr_i in the same cycle as a transfer -> counter reads 0.

Source files
------------

// File: rtl/wfg_axis_merge.sv
// wfg_axis_merge: two-source AXI-Stream merge with per-beat arbitration and a single registered output stage.
// Define WFG_AXIS_MERGE_CNT_EN to add per-source beat counters.
package wfg_axis_merge_pkg;
  typedef struct packed {
    logic        tvalid;
    logic [31:0] tdata;
  } axis_t;
endpackage

module wfg_axis_merge
  import wfg_axis_merge_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ctrl_en_q_i,
  input  logic [1:0] src_en_q_i,
  input  logic       arb_mode_q_i,
  input  axis_t      source_0,
  input  axis_t      source_1,
  output logic       wfg_axis_tready_source_0,
  output logic       wfg_axis_tready_source_1,
  output axis_t      merged,
  output logic       merged_tid_o,
`ifdef WFG_AXIS_MERGE_CNT_EN
  input  logic        cnt_clr_i,
  output logic [15:0] beat_cnt_0_o,
  output logic [15:0] beat_cnt_1_o,
`endif
  input  logic       wfg_axis_tready_merged
);
  axis_t merged_q, merged_d;
  logic tid_q, tid_d, last_q, last_d, load, xfer;
  logic [1:0] req, grant;
  logic [AXIS_DATA_WIDTH-1:0] data_sel;
  always_comb begin
    load = (!merged_q.tvalid || wfg_axis_tready_merged) && !rst;
    req = {source_1.tvalid, source_0.tvalid} & src_en_q_i & {2{ctrl_en_q_i}};
    grant = &req ? ((arb_mode_q_i || last_q) ? 2'b01 : 2'b10) : req;
    xfer = load && |grant;
    data_sel = grant[1] ? source_1.tdata : source_0.tdata;
    merged_d = merged_q;
    merged_d.tvalid = xfer || (merged_q.tvalid && !wfg_axis_tready_merged);
    merged_d.tdata = xfer ? data_sel : merged_q.tdata;
    tid_d = xfer ? grant[1] : tid_q;
    last_d = xfer ? grant[1] : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      merged_q <= '0;
      tid_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      merged_q <= merged_d;
      tid_q <= tid_d;
      last_q <= last_d;
    end
  end
  assign merged = merged_q;
  assign merged_tid_o = tid_q;
  assign wfg_axis_tready_source_0 = load && grant[0];
  assign wfg_axis_tready_source_1 = load && grant[1];
`ifdef WFG_AXIS_MERGE_CNT_EN
  logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  always_comb begin
    cnt0_d = cnt_clr_i ? 16'd0 : cnt0_q + {15'd0, xfer && grant[0]};
    cnt1_d = cnt_clr_i ? 16'd0 : cnt1_q + {15'd0, xfer && grant[1]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end
  assign beat_cnt_0_o = cnt0_q;
  assign beat_cnt_1_o = cnt1_q;
`endif
endmodule
